// File: rtl/bram_arbiter.sv
// Two-controller Wishbone B4 pipelined arbiter in front of a single bram peripheral.
// Define BRAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; the default is fixed priority to controller 0.
module bram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,

    input  logic [ADDR_WIDTH-1:0] c0_addr_i,
    input  logic [DATA_WIDTH-1:0] c0_data_i,
    output logic [DATA_WIDTH-1:0] c0_data_o,
    input  logic                  c0_we_i,
    input  logic                  c0_cycle_i,
    input  logic                  c0_strobe_i,
    output logic                  c0_stall_o,
    output logic                  c0_ack_o,

    input  logic [ADDR_WIDTH-1:0] c1_addr_i,
    input  logic [DATA_WIDTH-1:0] c1_data_i,
    output logic [DATA_WIDTH-1:0] c1_data_o,
    input  logic                  c1_we_i,
    input  logic                  c1_cycle_i,
    input  logic                  c1_strobe_i,
    output logic                  c1_stall_o,
    output logic                  c1_ack_o,

    output logic [ADDR_WIDTH-1:0] p_addr_o,
    output logic [DATA_WIDTH-1:0] p_data_o,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    output logic                  p_we_o,
    output logic                  p_cycle_o,
    output logic                  p_strobe_o,
    input  logic                  p_stall_i,
    input  logic                  p_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
    logic last_served;
    logic last_served_next;

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            last_served <= 1'b1;
        end else begin
            last_served <= last_served_next;
        end
    end
`endif

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN gives the peripheral one cycle to return the ack of a final strobe before a new grant.
    always_comb begin
        state_next = state;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
        last_served_next = last_served;
`endif
        case (state)
            IDLE: begin
                if (c0_cycle_i && c1_cycle_i) begin
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
                    state_next = last_served ? GRANT0 : GRANT1;
`else
                    state_next = GRANT0;
`endif
                end else if (c0_cycle_i) begin
                    state_next = GRANT0;
                end else if (c1_cycle_i) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (!c0_cycle_i) begin
                    state_next = DRAIN;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
                    last_served_next = 1'b0;
`endif
                end
            end
            GRANT1: begin
                if (!c1_cycle_i) begin
                    state_next = DRAIN;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
                    last_served_next = 1'b1;
`endif
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ack and stall are pure pass-through so the peripheral latency is not lengthened.
    always_comb begin
        p_addr_o   = c0_addr_i;
        p_data_o   = c0_data_i;
        p_we_o     = 1'b0;
        p_cycle_o  = 1'b0;
        p_strobe_o = 1'b0;
        c0_stall_o = 1'b1;
        c1_stall_o = 1'b1;
        c0_ack_o   = 1'b0;
        c1_ack_o   = 1'b0;
        case (state)
            GRANT0: begin
                p_addr_o   = c0_addr_i;
                p_data_o   = c0_data_i;
                p_we_o     = c0_we_i;
                p_cycle_o  = c0_cycle_i;
                p_strobe_o = c0_strobe_i;
                c0_stall_o = p_stall_i;
                c0_ack_o   = p_ack_i;
            end
            GRANT1: begin
                p_addr_o   = c1_addr_i;
                p_data_o   = c1_data_i;
                p_we_o     = c1_we_i;
                p_cycle_o  = c1_cycle_i;
                p_strobe_o = c1_strobe_i;
                c1_stall_o = p_stall_i;
                c1_ack_o   = p_ack_i;
            end
            default: begin
            end
        endcase
    end

    assign c0_data_o = p_data_i;
    assign c1_data_o = p_data_i;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a 1-cycle-latency bram model on the peripheral side.
// Grant-order expectations follow BRAM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_bram_arbiter;

    logic       wb_clock_i = 1'b0;
    logic       wb_reset_i;
    logic [9:0] c0_addr_i, c1_addr_i, p_addr_o;
    logic [7:0] c0_data_i, c1_data_i, c0_data_o, c1_data_o, p_data_o;
    logic [7:0] p_data_i = 8'h00;
    logic       c0_we_i, c0_cycle_i, c0_strobe_i, c0_stall_o, c0_ack_o;
    logic       c1_we_i, c1_cycle_i, c1_strobe_i, c1_stall_o, c1_ack_o;
    logic       p_we_o, p_cycle_o, p_strobe_o, p_stall_i;
    logic       p_ack_i = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:1023];

    bram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .wb_clock_i(wb_clock_i), .wb_reset_i(wb_reset_i),
        .c0_addr_i(c0_addr_i), .c0_data_i(c0_data_i), .c0_data_o(c0_data_o), .c0_we_i(c0_we_i),
        .c0_cycle_i(c0_cycle_i), .c0_strobe_i(c0_strobe_i), .c0_stall_o(c0_stall_o), .c0_ack_o(c0_ack_o),
        .c1_addr_i(c1_addr_i), .c1_data_i(c1_data_i), .c1_data_o(c1_data_o), .c1_we_i(c1_we_i),
        .c1_cycle_i(c1_cycle_i), .c1_strobe_i(c1_strobe_i), .c1_stall_o(c1_stall_o), .c1_ack_o(c1_ack_o),
        .p_addr_o(p_addr_o), .p_data_o(p_data_o), .p_data_i(p_data_i), .p_we_o(p_we_o),
        .p_cycle_o(p_cycle_o), .p_strobe_o(p_strobe_o), .p_stall_i(p_stall_i), .p_ack_i(p_ack_i)
    );

    always #5 wb_clock_i = ~wb_clock_i;

    // Simple bram: acks any non-stalled strobe one cycle later, read data registered.
    always @(posedge wb_clock_i) begin
        p_ack_i <= p_strobe_o && !p_stall_i;
        if (p_strobe_o && !p_stall_i) begin
            if (p_we_o) mem[p_addr_o] <= p_data_o;
            p_data_i <= mem[p_addr_o];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge wb_clock_i);
        #1;
    endtask

    task automatic test_reset();
        wb_reset_i = 1'b1;
        c0_cycle_i = 1'b1; c1_cycle_i = 1'b1; c0_strobe_i = 1'b1; c1_strobe_i = 1'b1;
        c0_we_i = 1'b1; c1_we_i = 1'b1;
        c0_addr_i = '0; c1_addr_i = '0; c0_data_i = '0; c1_data_i = '0;
        p_stall_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (p_cycle_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_p_cycle got=%b want=0", p_cycle_o); end
        total++; if (p_strobe_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_p_strobe got=%b want=0", p_strobe_o); end
        total++; if (p_we_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_p_we got=%b want=0", p_we_o); end
        total++; if ({c0_stall_o, c1_stall_o} !== 2'b11) begin bad++; $display("[TB] FAIL reset_stall got=%b%b want=11", c0_stall_o, c1_stall_o); end
        total++; if ({c0_ack_o, c1_ack_o} !== 2'b00) begin bad++; $display("[TB] FAIL reset_ack got=%b%b want=00", c0_ack_o, c1_ack_o); end
        c0_cycle_i = 1'b0; c1_cycle_i = 1'b0; c0_strobe_i = 1'b0; c1_strobe_i = 1'b0;
        c0_we_i = 1'b0; c1_we_i = 1'b0;
        wb_reset_i = 1'b0;
        tick();
    endtask

    task automatic test_write_read_c0();
        c0_cycle_i = 1'b1; c0_strobe_i = 1'b1; c0_we_i = 1'b1; c0_addr_i = 10'h003; c0_data_i = 8'h5A;
        #1;
        total++; if (c0_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_idle_stall got=%b want=1", c0_stall_o); end
        total++; if (p_strobe_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_idle_strobe got=%b want=0", p_strobe_o); end
        tick();
        total++; if (c0_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_grant_stall got=%b want=0", c0_stall_o); end
        total++; if (c1_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_other_stall got=%b want=1", c1_stall_o); end
        total++; if ({p_cycle_o, p_strobe_o, p_we_o} !== 3'b111) begin bad++; $display("[TB] FAIL wr_ctrl got=%b%b%b want=111", p_cycle_o, p_strobe_o, p_we_o); end
        total++; if (p_addr_o !== 10'h003) begin bad++; $display("[TB] FAIL wr_addr got=%h want=003", p_addr_o); end
        total++; if (p_data_o !== 8'h5A) begin bad++; $display("[TB] FAIL wr_data got=%h want=5a", p_data_o); end
        total++; if (c0_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_early_ack got=%b want=0", c0_ack_o); end
        tick();
        c0_strobe_i = 1'b1; c0_we_i = 1'b0;
        #1;
        total++; if (c0_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack got=%b want=1", c0_ack_o); end
        total++; if (c1_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_c1_ack got=%b want=0", c1_ack_o); end
        tick();
        c0_strobe_i = 1'b0;
        #1;
        total++; if (c0_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_ack got=%b want=1", c0_ack_o); end
        total++; if (c0_data_o !== 8'h5A) begin bad++; $display("[TB] FAIL rd_data got=%h want=5a", c0_data_o); end
        total++; if (c1_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_c1_ack got=%b want=0", c1_ack_o); end
        c0_cycle_i = 1'b0;
        #1;
        total++; if (p_cycle_o !== 1'b0) begin bad++; $display("[TB] FAIL drop_p_cycle got=%b want=0", p_cycle_o); end
        tick();
        tick();
    endtask

    task automatic test_contention();
        c0_cycle_i = 1'b1; c1_cycle_i = 1'b1;
        tick();
        total++; if ({c0_stall_o, c1_stall_o} !== 2'b01) begin bad++; $display("[TB] FAIL cont_first_grant got=%b%b want=01", c0_stall_o, c1_stall_o); end
        p_stall_i = 1'b1;
        #1;
        total++; if (c0_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL cont_periph_stall got=%b want=1", c0_stall_o); end
        p_stall_i = 1'b0;
        tick();
        total++; if (c1_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL cont_c1_wait got=%b want=1", c1_stall_o); end
        c0_cycle_i = 1'b0;
        tick();
        total++; if ({p_cycle_o, c1_stall_o} !== 2'b01) begin bad++; $display("[TB] FAIL cont_drain got=%b%b want=01", p_cycle_o, c1_stall_o); end
        tick();
        total++; if (c1_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL cont_idle_gap got=%b want=1", c1_stall_o); end
        tick();
        total++; if ({c0_stall_o, c1_stall_o, p_cycle_o} !== 3'b101) begin bad++; $display("[TB] FAIL cont_second_grant got=%b%b%b want=101", c0_stall_o, c1_stall_o, p_cycle_o); end
        c1_cycle_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_drain_ack();
        c1_cycle_i = 1'b1;
        tick();
        total++; if (c1_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_grant got=%b want=0", c1_stall_o); end
        c1_strobe_i = 1'b1; c1_we_i = 1'b1; c1_addr_i = 10'h155; c1_data_i = 8'h3C;
        tick();
        total++; if (c1_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL drain_beat_ack got=%b want=1", c1_ack_o); end
        c1_addr_i = 10'h156; c1_data_i = 8'hC3;
        c1_cycle_i = 1'b0;
        tick();
        c1_strobe_i = 1'b0; c1_we_i = 1'b0;
        #1;
        total++; if ({c0_ack_o, c1_ack_o} !== 2'b00) begin bad++; $display("[TB] FAIL drain_ack_dropped got=%b%b want=00", c0_ack_o, c1_ack_o); end
        total++; if (p_cycle_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_p_cycle got=%b want=0", p_cycle_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int winner;
        int expect_seq [3];
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
        expect_seq = '{0, 1, 0};
`else
        expect_seq = '{0, 0, 0};
`endif
        c0_cycle_i = 1'b1; c1_cycle_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            winner = -1;
            for (int k = 0; k < 6 && winner < 0; k++) begin
                tick();
                if (c0_stall_o === 1'b0) winner = 0;
                else if (c1_stall_o === 1'b0) winner = 1;
            end
            total++;
            if (winner !== expect_seq[r]) begin
                bad++; $display("[TB] FAIL b2b_grant_%0d got=%0d want=%0d", r, winner, expect_seq[r]);
            end
            tick();
            if (winner == 0) begin
                c0_cycle_i = 1'b0; tick(); c0_cycle_i = 1'b1;
            end else if (winner == 1) begin
                c1_cycle_i = 1'b0; tick(); c1_cycle_i = 1'b1;
            end
        end
        c0_cycle_i = 1'b0; c1_cycle_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_mid_burst();
        c1_cycle_i = 1'b1;
        tick();
        c1_strobe_i = 1'b1; c1_we_i = 1'b1; c1_addr_i = 10'h100; c1_data_i = 8'h10;
        tick();
        c1_addr_i = 10'h101; c1_data_i = 8'h11;
        tick();
        c1_addr_i = 10'h102; c1_data_i = 8'h12;
        wb_reset_i = 1'b1;
        #1;
        total++; if ({p_cycle_o, p_strobe_o, p_we_o} !== 3'b000) begin bad++; $display("[TB] FAIL rst_mid_ctrl got=%b%b%b want=000", p_cycle_o, p_strobe_o, p_we_o); end
        total++; if ({c0_ack_o, c1_ack_o} !== 2'b00) begin bad++; $display("[TB] FAIL rst_mid_ack got=%b%b want=00", c0_ack_o, c1_ack_o); end
        total++; if ({c0_stall_o, c1_stall_o} !== 2'b11) begin bad++; $display("[TB] FAIL rst_mid_stall got=%b%b want=11", c0_stall_o, c1_stall_o); end
        c1_cycle_i = 1'b0; c1_strobe_i = 1'b0; c1_we_i = 1'b0;
        tick();
        tick();
        wb_reset_i = 1'b0;
        tick();
        c1_cycle_i = 1'b1; c1_strobe_i = 1'b1; c1_we_i = 1'b1; c1_addr_i = 10'h200; c1_data_i = 8'hA5;
        #1;
        total++; if (c1_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL fresh_idle_stall got=%b want=1", c1_stall_o); end
        tick();
        total++; if ({c1_stall_o, p_cycle_o} !== 2'b01) begin bad++; $display("[TB] FAIL fresh_grant got=%b%b want=01", c1_stall_o, p_cycle_o); end
        total++; if (p_addr_o !== 10'h200) begin bad++; $display("[TB] FAIL fresh_addr got=%h want=200", p_addr_o); end
        total++; if (p_data_o !== 8'hA5) begin bad++; $display("[TB] FAIL fresh_data got=%h want=a5", p_data_o); end
        tick();
        c1_we_i = 1'b0;
        #1;
        total++; if (c1_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL fresh_wr_ack got=%b want=1", c1_ack_o); end
        tick();
        c1_strobe_i = 1'b0;
        #1;
        total++; if (c1_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL fresh_rd_ack got=%b want=1", c1_ack_o); end
        total++; if (c1_data_o !== 8'hA5) begin bad++; $display("[TB] FAIL fresh_rd_data got=%h want=a5", c1_data_o); end
        total++; if (c0_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL fresh_c0_ack got=%b want=0", c0_ack_o); end
        c1_cycle_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read_c0();
        test_contention();
        test_drain_ack();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
